seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
Parametrised sequential multiplier, successor to the fixed 4-bit combinational array multiplier. Computes a WIDTH x WIDTH product with a 2*WIDTH-bit result using radix-2 shift-add, one multiplier bit per clock. Supports per-operation signed or unsigned mode. Uses valid/ready handshakes on both sides so it can sit between pipelined producer and consumer stages in datapath blocks.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b, sgn are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
sgn  input  1  1 = two's-complement signed operands, 0 = unsigned; sampled with a and b.
out_valid  output  1  product is valid.
out_ready  input  1  consumer accepts the product.
product  output  2*WIDTH  result; signed or unsigned according to the captured sgn.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, internal accumulator, counter and operand registers=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge k, capture |a|, |b|, neg=sgn&&(a[MSB]^b[MSB]), clear the accumulator and counter, and go to CALC.
  - CALC: in_ready=0, out_valid=0. On each edge, if the current multiplier LSB=1, add the shifted multiplicand to the accumulator, then shift and increment the counter. On the WIDTH-th CALC edge (edge k+WIDTH), load product with the accumulator (two's-complement negated if neg) and go to DONE.
  - DONE: out_valid=1, product held stable. On out_valid&&out_ready, go to IDLE; product keeps its value and out_valid drops.
- Latency: out_valid rises after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles minimum, including the acceptance and drain edges.
- in_ready is high only in IDLE. Input changes outside IDLE are ignored.
- Backpressure: out_ready low in DONE holds the state indefinitely; product and out_valid must not change.
- Magnitude: in signed mode, -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in a WIDTH-bit unsigned value. (-2^(W-1))^2 = 2^(2W-2) fits in the signed 2W-bit result with no overflow. No overflow is possible in either mode.
- Zero operand: the full WIDTH cycles still run (no early termination), so latency is fixed.
- sgn=0: operands are treated as unsigned; the MSB does not affect sign.
- Reset mid-operation, in any state: immediately forces IDLE and zeroed outputs. A partial result is never emitted.
- out_ready high while not in DONE: no effect.

Decomposition:
- Package mult_pkg: state enum (IDLE, CALC, DONE) and a counter-width function clog2(WIDTH+1).
- One sub-module: mult_abs_neg (combinational, parametrised by width). Provides conditional two's-complement absolute value and negation, instantiated for operand conditioning and result fixup.
- The top level holds the FSM, counter, accumulator and handshake.

Test Plan:
1. WIDTH=4, unsigned: a=10, b=12, sgn=0 -> product=120 exactly 4 cycles after acceptance; a=15, b=15 -> 225.
2. WIDTH=8, signed: a=-7 (0xF9), b=9, sgn=1 -> product=0xFFC1 (-63); a=-128, b=-128 -> 0x4000; a=0x80, b=0x80, sgn=0 -> 0x4000.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, product stable, in_ready=0; then pulse out_ready -> IDLE next cycle, in_ready=1.
4. Back-to-back: keep in_valid high with a stream of 8 random operand pairs and out_ready=1 -> each result matches the reference model, and accepts occur only when in_ready=1, spaced WIDTH+2 cycles apart.
5. Reset mid-CALC: assert rst_n=0 at cycle 3 of CALC -> out_valid=0, product=0, in_ready=1 immediately (asynchronous); after release, a new 6x7 operation gives 42.
6. Zero and one operands: a=0, b=0xFF -> 0; a=1, b=0xFF, sgn=1 -> 0xFFFF; latency is still WIDTH cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_e : controller states
//   clog2   : ceil(log2(value)), minimum 1; sizes the bit counter
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res < 1) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/mult_abs_neg.sv
// Conditional two's-complement negation. When neg_i is set, res_o = -val_i,
// otherwise res_o = val_i. If neg_i is the operand's sign bit, this gives
// the absolute value. The most negative input maps to itself, which reads
// back correctly as the unsigned magnitude.
//   val_i [W-1:0] : input value
//   neg_i         : negate when 1
//   res_o [W-1:0] : result
module mult_abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-add multiplier, one multiplier bit per clock. The product is
// signed or unsigned, as selected by sgn. Both sides use valid/ready
// handshakes.
//   clk, rst_n           : clock and asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b and sgn are captured together)
//   a, b [WIDTH-1:0]     : multiplicand, multiplier
//   sgn                  : 1 = two's-complement operands
//   out_valid / out_ready: result handshake
//   product [2*WIDTH-1:0]: registered result, held after it drains
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | WIDTH shift-add steps over the magnitudes
// DONE  | out_valid high, product held until out_ready
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int               CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] acc_fix;

  mult_abs_neg #(.W(WIDTH)) u_abs_a (
    .val_i (a),
    .neg_i (sgn & a[WIDTH-1]),
    .res_o (abs_a)
  );

  mult_abs_neg #(.W(WIDTH)) u_abs_b (
    .val_i (b),
    .neg_i (sgn & b[WIDTH-1]),
    .res_o (abs_b)
  );

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Sign fixup is applied to the value the last step produces, so the
  // product loads on the same edge as the final add.
  mult_abs_neg #(.W(2*WIDTH)) u_fix (
    .val_i (acc_d),
    .neg_i (neg_q),
    .res_o (acc_fix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q    <= {{WIDTH{1'b0}}, abs_a};
            mplier_q   <= abs_b;
            neg_q      <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            product_q   <= acc_fix;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: an 8-bit instance for the
// vector table and multi-cycle sequences, and a 4-bit instance for the
// narrow unsigned case.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, sgn, out_valid, out_ready;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;

  logic           in_valid4, in_ready4, sgn4, out_valid4, out_ready4;
  logic [3:0]     a4, b4;
  logic [7:0]     product4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_shift_add_multiplier #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .sgn       (sgn4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .product   (product4)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge with the 8-bit DUT idle.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                        input logic [15:0] exp, input string tag);
    int n;
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a = va; b = vb; sgn = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = ~vb; sgn = ~vs;
    chk({tag, " in_ready in calc"}, 32'(in_ready), 32'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 4 * W);
    chk({tag, " latency"}, 32'(n), 32'(W));
    chk({tag, " product"}, 32'(product), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drained"}, {30'd0, out_valid, in_ready}, 32'b01);
    chk({tag, " product held after drain"}, 32'(product), 32'(exp));
  endtask

  task automatic run_op4(input logic [3:0] va, input logic [3:0] vb,
                         input logic [7:0] exp, input string tag);
    int n;
    a4 = va; b4 = vb; sgn4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid4 && n < 16);
    chk({tag, " latency"}, 32'(n), 32'd4);
    chk({tag, " product"}, 32'(product4), 32'(exp));
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk({tag, " back to idle"}, 32'(in_ready4), 32'd1);
  endtask

  initial begin
    int          n, acc_cyc, prev_cyc, sa, sb;
    logic [7:0]  va, vb;
    logic        vs;
    logic [15:0] exp;

    vecs[0]  = '{8'h0A, 8'h0C, 1'b0, 16'h0078};  // 10*12 = 120
    vecs[1]  = '{8'h0F, 8'h0F, 1'b0, 16'h00E1};  // 225
    vecs[2]  = '{8'hF9, 8'h09, 1'b1, 16'hFFC1};  // -7*9 = -63
    vecs[3]  = '{8'h80, 8'h80, 1'b1, 16'h4000};  // -128*-128
    vecs[4]  = '{8'h80, 8'h80, 1'b0, 16'h4000};  // 128*128
    vecs[5]  = '{8'h00, 8'hFF, 1'b0, 16'h0000};
    vecs[6]  = '{8'h01, 8'hFF, 1'b1, 16'hFFFF};  // 1*-1
    vecs[7]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};  // 255*255
    vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};  // -1*-1
    vecs[9]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};  // 127*-128 = -16256
    vecs[10] = '{8'h03, 8'hFD, 1'b1, 16'hFFF7};  // 3*-3
    vecs[11] = '{8'hFD, 8'h03, 1'b0, 16'h02F7};  // 253*3 = 759

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sgn = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; sgn4 = 1'b0;
    #12;
    chk("reset w8 ready/valid", {30'd0, in_ready, out_valid}, 32'b10);
    chk("reset w8 product", 32'(product), 32'd0);
    chk("reset w4 ready/valid", {30'd0, in_ready4, out_valid4}, 32'b10);
    chk("reset w4 product", 32'(product4), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op4(4'd10, 4'd12, 8'd120, "w4 10x12");
    run_op4(4'd15, 4'd15, 8'd225, "w4 15x15");

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].p, $sformatf("vec%0d", i));

    // Backpressure: 255*255 held in DONE for 10 cycles.
    a = 8'hFF; b = 8'hFF; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp reached done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold %0d", i), {out_valid, in_ready, 14'd0, product}, {1'b1, 1'b0, 14'd0, 16'hFE01});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release", {out_valid, in_ready, 14'd0, product}, {1'b0, 1'b1, 14'd0, 16'hFE01});

    // Back-to-back stream with in_valid and out_ready held high.
    in_valid = 1'b1; out_ready = 1'b1; prev_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      va = 8'($urandom); vb = 8'($urandom); vs = 1'($urandom);
      sa = vs ? int'($signed(va)) : int'(va);
      sb = vs ? int'($signed(vb)) : int'(vb);
      exp = 16'(sa * sb);
      a = va; b = vb; sgn = vs;
      n = 0;
      while (!in_ready && n < 4 * W) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("b2b%0d ready before accept", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
      if (i > 0) chk($sformatf("b2b%0d spacing", i), 32'(acc_cyc - prev_cyc), 32'(W + 2));
      prev_cyc = acc_cyc;
      n = 0;
      while (!out_valid && n < 4 * W) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("b2b%0d latency", i), 32'(n), 32'(W));
      chk($sformatf("b2b%0d a=%0h b=%0h s=%0d", i, va, vb, vs), 32'(product), 32'(exp));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset during the third CALC cycle, asserted between clock edges.
    chk("pre-reset product nonzero", 32'(product != 16'd0), 32'd1);
    a = 8'h55; b = 8'h33; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {out_valid, in_ready, 14'd0, product}, {1'b0, 1'b1, 30'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after reset no result", 32'(out_valid), 32'd0);
    run_op(8'd6, 8'd7, 1'b0, 16'd42, "post-reset 6x7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
